dummy_seq_ctrl: RTL and testbench



---
 rtl/dummy_seq_pkg.sv | 33 +++
 rtl/dummy_seq_ctrl_if.sv | 41 ++++
 rtl/dummy_seq_exp_pipe.sv | 40 ++++
 rtl/dummy_seq_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_dummy_seq_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dummy_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dummy_seq_pkg
// Description : Shared types, default sizes and helpers for the dummy_seq_ctrl
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dummy_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_DRIVE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    localparam int DEF_PAT_W      = 8;
    localparam int DEF_LAT        = 1;
    localparam int DEF_RST_CYCLES = 2;

    // One phase counter is reused for reset hold, bit index and drain, so it
    // must hold the largest terminal value (max - 1) of the three.
    function automatic int cnt_width(input int pat_w, input int lat, input int rst_cycles);
        int m;
        m = pat_w;
        if (lat > m)        m = lat;
        if (rst_cycles > m) m = rst_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dummy_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dummy_seq_ctrl_if
// Description : Request/result bundle between a test driver and the
//               sequencer. Optional macro: DUMMY_SEQ_FIRST_FAIL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface dummy_seq_ctrl_if #(
    parameter int PAT_W = 8
);
    localparam int ERR_W = $clog2(PAT_W + 1);

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
`ifdef DUMMY_SEQ_FIRST_FAIL_EN
    logic                     first_fail_vld;
    logic [$clog2(PAT_W)-1:0] first_fail_idx;
`endif

    modport master (
        output start, pattern,
        input  busy, done, pass, err_cnt
`ifdef DUMMY_SEQ_FIRST_FAIL_EN
        , input first_fail_vld, first_fail_idx
`endif
    );

    modport slave (
        input  start, pattern,
        output busy, done, pass, err_cnt
`ifdef DUMMY_SEQ_FIRST_FAIL_EN
        , output first_fail_vld, first_fail_idx
`endif
    );

endinterface
`default_nettype wire

// File: rtl/dummy_seq_exp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dummy_seq_exp_pipe
// Description : Delay line of {valid, expected bit} aligning launched bits
//               with the DUT output sample point.
// Revision    : 1.0 - initial release
// ============================================================================
module dummy_seq_exp_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic in_vld,
    input  logic in_bit,
    output logic out_vld,
    output logic out_bit
);
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] bit_q, bit_d;

    always_comb begin
        vld_d = {vld_q[DEPTH-2:0], in_vld};
        bit_d = {bit_q[DEPTH-2:0], in_bit};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
            bit_q <= '0;
        end else begin
            vld_q <= vld_d;
            bit_q <= bit_d;
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_bit = bit_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dummy_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dummy_seq_ctrl
// Description : Resets a single-flop DUT, shifts a pattern through it and
//               counts mismatches on its output. Optional macro:
//               DUMMY_SEQ_FIRST_FAIL_EN (first failing bit index capture).
// Revision    : 1.0 - initial release
// ============================================================================
module dummy_seq_ctrl
    import dummy_seq_pkg::*;
#(
    parameter int PAT_W      = DEF_PAT_W,
    parameter int LAT        = DEF_LAT,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic             clk,
    input  logic             rstn,
    dummy_seq_ctrl_if.slave  bus,
    output logic             dut_rstn,
    output logic             dut_d,
    input  logic             dut_q
);
    localparam int ERR_W = $clog2(PAT_W + 1);
    localparam int CNT_W = cnt_width(PAT_W, LAT, RST_CYCLES);

    localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_PAT_LAST = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] C_LAT_LAST = CNT_W'(LAT - 1);
    localparam logic [ERR_W-1:0] C_ERR_MAX  = ERR_W'(PAT_W);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             dut_rstn_q, dut_rstn_d;
    logic             dut_d_q, dut_d_d;

    logic             accept;
    logic             push_vld;
    logic             push_bit;
    logic             exp_vld;
    logic             exp_bit;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [PAT_W-1:0] pat_shift;

    dummy_seq_exp_pipe #(
        .DEPTH (LAT + 1)
    ) u_exp_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .in_vld  (push_vld),
        .in_bit  (push_bit),
        .out_vld (exp_vld),
        .out_bit (exp_bit)
    );

    assign accept    = (state_q == ST_IDLE) && bus.start;
    assign mismatch  = exp_vld && (exp_bit != dut_q);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign pat_shift = pat_q >> cnt_inc;

    always_comb begin
        err_next = err_cnt_q;
        if (mismatch && (err_cnt_q != C_ERR_MAX)) begin
            err_next = err_cnt_q + ERR_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_next;
        dut_rstn_d = dut_rstn_q;
        dut_d_d    = dut_d_q;
        push_vld   = 1'b0;
        push_bit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dut_rstn_d = 1'b0;
                dut_d_d    = 1'b0;
                if (accept) begin
                    pat_d     = bus.pattern;
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_RST;
                end
            end
            ST_RST: begin
                if (cnt_q == C_RST_LAST) begin
                    state_d    = ST_DRIVE;
                    cnt_d      = '0;
                    dut_rstn_d = 1'b1;
                    dut_d_d    = pat_q[0];
                    push_vld   = 1'b1;
                    push_bit   = pat_q[0];
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            // cnt_q is the index of the bit currently on dut_d.
            ST_DRIVE: begin
                if (cnt_q == C_PAT_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                    dut_d_d = 1'b0;
                end else begin
                    cnt_d    = cnt_inc;
                    dut_d_d  = pat_shift[0];
                    push_vld = 1'b1;
                    push_bit = pat_shift[0];
                end
            end
            ST_DRAIN: begin
                if (cnt_q == C_LAT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                dut_rstn_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            dut_rstn_q <= 1'b0;
            dut_d_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            dut_rstn_q <= dut_rstn_d;
            dut_d_q    <= dut_d_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_cnt_q;
    assign dut_rstn    = dut_rstn_q;
    assign dut_d       = dut_d_q;

`ifdef DUMMY_SEQ_FIRST_FAIL_EN
    localparam int FF_W = $clog2(PAT_W);

    logic            ff_vld_q, ff_vld_d;
    logic [FF_W-1:0] ff_idx_q, ff_idx_d;
    logic [FF_W-1:0] cmp_idx_q, cmp_idx_d;

    // cmp_idx_q tracks which bit index the pipe output currently represents.
    always_comb begin
        ff_vld_d  = ff_vld_q;
        ff_idx_d  = ff_idx_q;
        cmp_idx_d = cmp_idx_q;
        if (accept) begin
            ff_vld_d  = 1'b0;
            ff_idx_d  = '0;
            cmp_idx_d = '0;
        end else begin
            if (exp_vld) begin
                cmp_idx_d = cmp_idx_q + FF_W'(1);
            end
            if (mismatch && !ff_vld_q) begin
                ff_vld_d = 1'b1;
                ff_idx_d = cmp_idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ff_vld_q  <= 1'b0;
            ff_idx_q  <= '0;
            cmp_idx_q <= '0;
        end else begin
            ff_vld_q  <= ff_vld_d;
            ff_idx_q  <= ff_idx_d;
            cmp_idx_q <= cmp_idx_d;
        end
    end

    assign bus.first_fail_vld = ff_vld_q;
    assign bus.first_fail_idx = ff_idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dummy_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dummy_seq_ctrl
// Description : Directed vector bench for dummy_seq_ctrl with one-flop,
//               two-flop and tied-low DUT models on dut_q.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dummy_seq_ctrl;
    localparam int PAT_W      = 8;
    localparam int LAT        = 1;
    localparam int RST_CYCLES = 2;
    localparam int RUN_LAT    = RST_CYCLES + PAT_W + LAT;  // 11 edges accept -> done

    logic       clk = 1'b0;
    logic       rstn;
    logic       dut_rstn;
    logic       dut_d;
    logic       dut_q;
    logic [1:0] mode;   // 0: one flop, 1: two flops, 2: tied low
    logic       f1_q, f2_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dummy_seq_ctrl_if #(.PAT_W(PAT_W)) bus ();

    dummy_seq_ctrl #(
        .PAT_W      (PAT_W),
        .LAT        (LAT),
        .RST_CYCLES (RST_CYCLES)
    ) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.slave),
        .dut_rstn (dut_rstn),
        .dut_d    (dut_d),
        .dut_q    (dut_q)
    );

    always @(posedge clk) begin
        if (!dut_rstn) begin
            f1_q <= 1'b0;
            f2_q <= 1'b0;
        end else begin
            f1_q <= dut_d;
            f2_q <= f1_q;
        end
    end

    assign dut_q = (mode == 2'd0) ? f1_q : (mode == 2'd1) ? f2_q : 1'b0;

    typedef struct packed {
        logic [7:0] pat;
        logic [1:0] mode;
        logic [3:0] err;
        logic       pass;
        logic [2:0] ffidx;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Caller is 1 time unit after an edge with the sequencer idle.
    task automatic run_vec(input vec_t v, input string tag);
        int         n;
        logic [7:0] dseq;
        mode        = v.mode;
        dseq        = '0;
        bus.start   = 1'b1;
        bus.pattern = v.pat;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " busy_after_accept"}, int'(bus.busy), 1);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n >= RST_CYCLES && n < RST_CYCLES + PAT_W) dseq[n - RST_CYCLES] = dut_d;
        end
        check({tag, " done_latency"}, n, RUN_LAT);
        check({tag, " dut_d_seq"}, int'(dseq), int'(v.pat));
        check({tag, " err_cnt"}, int'(bus.err_cnt), int'(v.err));
        check({tag, " pass"}, int'(bus.pass), int'(v.pass));
`ifdef DUMMY_SEQ_FIRST_FAIL_EN
        check({tag, " ff_vld"}, int'(bus.first_fail_vld), int'(v.err != 0));
        if (v.err != 0) check({tag, " ff_idx"}, int'(bus.first_fail_idx), int'(v.ffidx));
`endif
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, int'(bus.done), 0);
        check({tag, " busy_cleared"}, int'(bus.busy), 0);
        check({tag, " dut_rstn_low"}, int'(dut_rstn), 0);
    endtask

    initial begin
        int ndone;
        int last;
        int first_lat;
        int err_at_done;

        vecs[0] = '{8'hA5, 2'd0, 4'd0, 1'b1, 3'd0};
        vecs[1] = '{8'hFF, 2'd2, 4'd8, 1'b0, 3'd0};
        vecs[2] = '{8'h01, 2'd1, 4'd2, 1'b0, 3'd0};
        vecs[3] = '{8'h3C, 2'd0, 4'd0, 1'b1, 3'd0};
        vecs[4] = '{8'h00, 2'd2, 4'd0, 1'b1, 3'd0};
        vecs[5] = '{8'h80, 2'd1, 4'd1, 1'b0, 3'd7};
        vecs[6] = '{8'h55, 2'd1, 4'd8, 1'b0, 3'd0};
        vecs[7] = '{8'h10, 2'd2, 4'd1, 1'b0, 3'd4};

        rstn        = 1'b0;
        mode        = 2'd0;
        bus.start   = 1'b0;
        bus.pattern = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", int'(bus.busy), 0);
        check("rst done", int'(bus.done), 0);
        check("rst pass", int'(bus.pass), 0);
        check("rst err_cnt", int'(bus.err_cnt), 0);
        check("rst dut_rstn", int'(dut_rstn), 0);
        check("rst dut_d", int'(dut_d), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Second start five cycles after accept must be ignored.
        mode        = 2'd2;
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        ndone       = 0;
        first_lat   = -1;
        err_at_done = -1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (first_lat < 0) begin
                    first_lat   = e;
                    err_at_done = int'(bus.err_cnt);
                end
            end
            if (e == 5) begin
                bus.start   = 1'b1;
                bus.pattern = 8'h00;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("restart done_count", ndone, 1);
        check("restart latency", first_lat, RUN_LAT);
        check("restart err_cnt", err_at_done, 8);

        // Reset while bit 3 is on dut_d.
        mode        = 2'd2;
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (RST_CYCLES + 3) @(posedge clk);
        #1;
        check("midrst err_before", int'(bus.err_cnt), 2);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("midrst busy", int'(bus.busy), 0);
        check("midrst dut_rstn", int'(dut_rstn), 0);
        check("midrst err_cnt", int'(bus.err_cnt), 0);
        check("midrst dut_d", int'(dut_d), 0);
        ndone = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("midrst no_done", ndone, 0);
        run_vec(vecs[0], "after_rst");

        // start held 40 edges: accepts at 0,13,26,39 -> four done pulses.
        mode        = 2'd0;
        bus.start   = 1'b1;
        bus.pattern = 8'h3C;
        ndone       = 0;
        last        = -1;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            #1;
            if (e == 39) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                check($sformatf("held pass%0d", ndone), int'(bus.pass), 1);
                if (last >= 0) check($sformatf("held gap%0d", ndone), e - last, RUN_LAT + 2);
                last = e;
            end
        end
        check("held done_count", ndone, 4);
        check("held idle_at_end", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
